// File: rtl/sha_k_pkg.sv
// Shared SHA-2 round-constant definitions: the 80-entry SHA-512 K table,
// round counts, mode encoding and small helpers used by the sequencer.
package sha_k_pkg;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;

  typedef enum logic {
    MODE_256 = 1'b0,
    MODE_512 = 1'b1
  } sha_mode_e;

  // SHA-256 constants are the upper 32 bits of the first 64 entries.
  localparam logic [63:0] K512 [ROUNDS_512] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  function automatic logic [6:0] last_round(sha_mode_e m);
    return (m == MODE_512) ? 7'(ROUNDS_512 - 1) : 7'(ROUNDS_256 - 1);
  endfunction

  function automatic logic [63:0] fmt_k(sha_mode_e m, logic [63:0] k);
    return (m == MODE_512) ? k : {32'h0, k[63:32]};
  endfunction

endpackage

// File: rtl/k_const_rom.sv
// Combinational round-index to K-constant lookup; only the entries reachable
// in the supported modes are built.
module k_const_rom
  import sha_k_pkg::*;
#(
  parameter bit SUPPORT_SHA512 = 1'b1
) (
  input  logic [6:0]  idx,
  output logic [63:0] k
);

  localparam int DEPTH = SUPPORT_SHA512 ? ROUNDS_512 : ROUNDS_256;

  always_comb begin
    k = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx == 7'(i)) k = K512[i];
    end
  end

endmodule

// File: rtl/k_const_sequencer.sv
// Streams SHA-256 or SHA-512 round constants over a valid/ready handshake,
// one beat per round, with abort and a completion pulse.
module k_const_sequencer
  import sha_k_pkg::*;
#(
  parameter bit SUPPORT_SHA512 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic        abort,
  input  logic        k_ready,
  output logic        k_valid,
  output logic [63:0] k_data,
  output logic [6:0]  k_round,
  output logic        k_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e    state;
  sha_mode_e mode_lat;
  sha_mode_e start_mode;
  sha_mode_e cur_mode;
  logic [6:0]  rom_idx;
  logic [63:0] rom_k;
  logic [63:0] next_data;
  logic        xfer;

  // The ROM is addressed with the round that will be presented next, so the
  // registered k_data is ready in the cycle after start or after a transfer.
  always_comb begin
    start_mode = sha_mode_e'(SUPPORT_SHA512 & mode);
    cur_mode   = (state == IDLE) ? start_mode : mode_lat;
    rom_idx    = (state == IDLE) ? 7'd0 : k_round + 7'd1;
    next_data  = fmt_k(cur_mode, rom_k);
    xfer       = k_valid && k_ready;
  end

  k_const_rom #(
    .SUPPORT_SHA512(SUPPORT_SHA512)
  ) u_rom (
    .idx(rom_idx),
    .k  (rom_k)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mode_lat <= MODE_256;
      k_valid  <= 1'b0;
      k_data   <= '0;
      k_round  <= '0;
      k_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= RUN;
            mode_lat <= start_mode;
            k_round  <= '0;
            k_data   <= next_data;
            k_valid  <= 1'b1;
            k_last   <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // Abort outranks a transfer in the same cycle, including the last one.
          if (abort || (xfer && k_last)) begin
            state   <= IDLE;
            k_round <= '0;
            k_data  <= '0;
            k_valid <= 1'b0;
            k_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= !abort;
          end else if (xfer) begin
            k_round <= k_round + 7'd1;
            k_data  <= next_data;
            k_last  <= ((k_round + 7'd1) == last_round(mode_lat));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k_const_sequencer.sv
// Scoreboard bench for k_const_sequencer: expected beats are queued at start
// and popped on every accepted transfer.
module tb_k_const_sequencer;

  typedef struct {
    logic [63:0] data;
    logic [6:0]  round;
    logic        last;
  } beat_t;

  localparam logic [63:0] TB_K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        abort = 1'b0;
  logic        k_ready = 1'b0;
  logic        k_valid;
  logic [63:0] k_data;
  logic [6:0]  k_round;
  logic        k_last;
  logic        busy;
  logic        done;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  k_const_sequencer #(
    .SUPPORT_SHA512(1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .abort  (abort),
    .k_ready(k_ready),
    .k_valid(k_valid),
    .k_data (k_data),
    .k_round(k_round),
    .k_last (k_last),
    .busy   (busy),
    .done   (done)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push_seq(input bit m);
    int          last;
    beat_t       b;
    logic [63:0] kv;
    last = m ? 79 : 63;
    for (int r = 0; r <= last; r++) begin
      kv      = TB_K[r];
      b.data  = m ? kv : {32'h0, kv[63:32]};
      b.round = 7'(r);
      b.last  = (r == last);
      sb.push_back(b);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_data"}, k_data, 64'h0);
    check_val({tag, "_ctl"}, {53'h0, k_valid, k_last, busy, done, k_round}, 64'h0);
  endtask

  // abort_at / rst_at < 0 disable that event; disturb toggles start and mode mid-run
  task automatic run_seq(input bit m, input int rdy_pct, input int abort_at,
                         input int rst_at, input bit disturb);
    beat_t       b;
    bit          finished;
    logic [63:0] first_exp;
    finished = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = m; abort = 1'b0; k_ready = 1'b0;
    sb.delete();
    push_seq(m);
    @(negedge clk);
    start = 1'b0;
    check_val("valid_after_start", k_valid, 1);
    check_val("busy_after_start", busy, 1);
    first_exp = m ? 64'h428a2f98d728ae22 : 64'h00000000428a2f98;
    check_val("beat0", k_data, first_exp);
    $display("sequence mode=%0d ready_pct=%0d abort_at=%0d rst_at=%0d disturb=%0d",
             m, rdy_pct, abort_at, rst_at, disturb);
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      k_ready = ($urandom_range(99) < rdy_pct);
      check_val("done_in_run", done, 0);
      check_val("busy_in_run", busy, 1);
      check_val("valid_in_run", k_valid, 1);
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL scoreboard_empty: got round %0d expected no further beat", k_round);
        finished = 1'b1;
      end else begin
        b = sb[0];
        check_val("k_data", k_data, b.data);
        check_val("k_round", k_round, b.round);
        check_val("k_last", k_last, b.last);
        if (disturb) begin
          start = !b.last && ($urandom_range(1) == 1);
          mode  = ($urandom_range(1) == 1);
        end
        if (abort_at >= 0 && k_round == 7'(abort_at)) begin
          abort = 1'b1; k_ready = 1'b1;
          @(negedge clk);
          abort = 1'b0; start = 1'b0;
          check_all_zero("after_abort");
          @(negedge clk);
          check_val("no_done_after_abort", done, 0);
          check_val("idle_after_abort", k_valid, 0);
          sb.delete();
          finished = 1'b1;
        end else if (rst_at >= 0 && k_round == 7'(rst_at)) begin
          #1 rst = 1'b0;
          #1 check_all_zero("async_rst");
          sb.delete();
          @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          check_all_zero("after_rst_release");
          finished = 1'b1;
        end else begin
          if (k_ready) begin
            void'(sb.pop_front());
            if (b.last) begin
              start = 1'b0;
              @(negedge clk);
              check_val("done_pulse", done, 1);
              check_val("valid_after_last", k_valid, 0);
              check_val("busy_after_last", busy, 0);
              check_val("round_wrap", k_round, 0);
              @(negedge clk);
              check_val("done_one_cycle", done, 0);
              finished = 1'b1;
            end
          end
          if (!finished) @(negedge clk);
        end
      end
    end
    if (!finished) begin
      vectors++; miscompares++;
      $display("FAIL timeout: got %0d beats outstanding expected 0", sb.size());
    end
    start = 1'b0; k_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    start = 1'b1; abort = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_val("start_abort_idle_valid", k_valid, 0);
    check_val("start_abort_idle_busy", busy, 0);

    run_seq(1'b1, 100, -1, -1, 1'b0);
    run_seq(1'b0, 100, -1, -1, 1'b0);
    run_seq(1'b1, 50, -1, -1, 1'b0);
    run_seq(1'b1, 100, 10, -1, 1'b0);
    run_seq(1'b1, 100, -1, -1, 1'b0);
    run_seq(1'b1, 100, -1, 40, 1'b0);
    run_seq(1'b0, 100, -1, -1, 1'b0);
    run_seq(1'b1, 70, -1, -1, 1'b1);
    run_seq(1'b0, 70, -1, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/k_const_sequencer.md
K_CONST_SEQUENCER -- requirements
Module: k_const_sequencer

Interface
REQ-001 The block SHALL have parameter SUPPORT_SHA512, default 1, meaning that 80-round SHA-512 mode is available; when 0, only the 64-round SHA-256 table is built and mode is ignored.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin one constant sequence.
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = SHA-256 (64 rounds), 1 = SHA-512 (80 rounds); sampled only when start is accepted.
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous cancel of the current sequence.
REQ-007 The block SHALL have port k_ready, input, 1 bit: consumer accepts the current beat.
REQ-008 The block SHALL have port k_valid, output, 1 bit: k_data, k_round and k_last are valid.
REQ-009 The block SHALL have port k_data, output, 64 bits: round constant.
REQ-010 The block SHALL have port k_round, output, 7 bits: round index of k_data.
REQ-011 The block SHALL have port k_last, output, 1 bit: the current beat is the final round.
REQ-012 The block SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sequence completes normally.

Function
REQ-014 The block SHALL have states IDLE and RUN.
REQ-015 In IDLE with start=1 and abort=0, the block SHALL latch mode (forced to 0 if SUPPORT_SHA512=0), set the round to 0 and enter RUN; k_valid SHALL rise on the next cycle.
REQ-016 In RUN, k_data SHALL equal K512[r] when mode=1, and {32'h0, K512[r][63:32]} when mode=0, where r = k_round. The SHA-256 constant is the upper half of the SHA-512 entry.
REQ-017 A beat SHALL transfer only when k_valid=1 and k_ready=1; without a transfer, k_data, k_round and k_last SHALL hold stable.
REQ-018 On each transfer with r < LAST, r SHALL increment by 1 and the new beat SHALL present in the next cycle with no bubble. LAST is 63 when mode=0 and 79 when mode=1.
REQ-019 k_last SHALL equal (k_valid and r == LAST).
REQ-020 A transfer with k_last=1 SHALL return the block to IDLE, deassert k_valid, and pulse done for exactly 1 cycle in the following cycle. r SHALL wrap to 0.
REQ-021 start while in RUN SHALL be ignored, and mode changes during RUN SHALL be ignored.
REQ-022 abort=1 in RUN SHALL return the block to IDLE next cycle with k_valid=0, r=0, and no done pulse; abort has priority over any same-cycle transfer.
REQ-023 If start and abort are both 1 in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-024 busy SHALL be 1 exactly while in RUN.
REQ-025 All outputs SHALL be registered and SHALL have no combinational path from any input.

Reset
REQ-026 When rst=0, the block SHALL asynchronously force IDLE, r=0, latched mode=0, and k_valid, k_data, k_round, k_last, busy and done all to 0.
REQ-027 Reset asserted mid-sequence SHALL discard that sequence; after release, a new start SHALL be required.

Structure
REQ-028 The shared package sha_k_pkg SHALL hold the 80-entry 64-bit K512 table, the ROUNDS_256=64 and ROUNDS_512=80 constants, and the mode encoding.
REQ-029 Sub-module k_const_rom SHALL provide the combinational index-to-constant lookup, with its depth set by SUPPORT_SHA512.

Verification
REQ-030 Scenario: mode=1, start, k_ready held 1 -> 80 back-to-back beats; beat 0 = 64'h428a2f98d728ae22; beat 79 = 64'h6c44198c4a475817 with k_last=1; done pulses one cycle later.
REQ-031 Scenario: mode=0, start -> 64 beats; beat 0 = 64'h00000000428a2f98; beat 63 = 64'h00000000c67178f2 with k_last=1.
REQ-032 Scenario: k_ready toggling randomly in mode 1 -> outputs hold during stalls; the accepted sequence equals K512[0..79] in order with no loss or duplication.
REQ-033 Scenario: abort at round 10 -> k_valid=0 next cycle, no done; a following start restarts at round 0 with 64'h428a2f98d728ae22 (mode 1).
REQ-034 Scenario: rst=0 at round 40 -> all outputs 0 immediately; after release, start with mode=0 yields 64'h00000000428a2f98.
REQ-035 Scenario: start re-asserted mid-run and mode flipped mid-run -> the sequence continues unchanged to its original LAST.
